// File: rtl/fifo_param_pkg.sv
// Shared helpers and types for the parametrised FIFO: pointer sizing,
// parameter-legality checks and the registered status-flag bundle.
package fifo_param_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                                       almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer side of the FIFO: write/read requests, data and status.
interface fifo_param_if
    import fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int COUNT_W = ptr_w(DEPTH);

    logic               sclr;
    logic               wren;
    logic [DATA_W-1:0]  din;
    logic               rden;
    logic [DATA_W-1:0]  dout;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [COUNT_W-1:0] count;
    logic               overflow;
    logic               underflow;

    modport master (
        output sclr, wren, din, rden,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  sclr, wren, din, rden,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and a selectable first-word-fall-through or registered read.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 1
) (
    input  logic         clk,
    input  logic         reset,
    fifo_param_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] AF_C = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_C = PTR_W'(AE_THRESH);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("fifo_param: DEPTH=%0d must be a power of two and >= 4", DEPTH);
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
        $error("fifo_param: AF_THRESH=%0d outside 1..DEPTH-1", AF_THRESH);
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 2) begin : g_bad_ae
        $error("fifo_param: AE_THRESH=%0d outside 0..DEPTH-2", AE_THRESH);
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    flags_t            flags_q, flags_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              wr_ok, rd_ok, ram_we;

    always_comb begin
        // A full FIFO still takes a write when the head is popped on the same edge.
        wr_ok    = bus.wren & (~flags_q.full | bus.rden);
        rd_ok    = bus.rden & ~flags_q.empty;
        ram_we   = wr_ok & ~bus.sclr;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_ok);
        dout_d   = rd_ok ? ram_rdata : dout_q;
        flags_d  = flags_q;
        flags_d.overflow  = bus.wren & flags_q.full & ~bus.rden;
        flags_d.underflow = bus.rden & flags_q.empty;
        if (bus.sclr) begin
            wr_ptr_d          = '0;
            rd_ptr_d          = '0;
            dout_d            = '0;
            flags_d.overflow  = 1'b0;
            flags_d.underflow = 1'b0;
        end
        // Status is derived from the next pointers so it moves on the same edge.
        count_d              = wr_ptr_d - rd_ptr_d;
        flags_d.full         = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                               (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
        flags_d.empty        = (wr_ptr_d == rd_ptr_d);
        flags_d.almost_full  = (count_d >= AF_C);
        flags_d.almost_empty = (count_d <= AE_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= FLAGS_RESET;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            dout_q   <= dout_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (bus.din),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign bus.dout = flags_q.empty ? '0 : ram_rdata;
    end else begin : g_reg
        assign bus.dout = dout_q;
    end

    assign bus.full         = flags_q.full;
    assign bus.empty        = flags_q.empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.overflow     = flags_q.overflow;
    assign bus.underflow    = flags_q.underflow;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: an FWFT and a registered-read instance share one stimulus
// stream and are both compared against a queue-based model of the FIFO.
module tb_fifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sclr = 1'b0, wren = 1'b0, rden = 1'b0;
    logic [DW-1:0] din = '0;

    always #5 clk = ~clk;

    fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus1 ();
    fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus0 ();

    assign bus1.sclr = sclr;
    assign bus1.wren = wren;
    assign bus1.rden = rden;
    assign bus1.din  = din;
    assign bus0.sclr = sclr;
    assign bus0.wren = wren;
    assign bus0.rden = rden;
    assign bus0.din  = din;

    fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));

    // {flags+count of FWFT dut, flags+count of registered dut, dout FWFT, dout registered}
    logic [37:0] obs;
    assign obs = {bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
                  bus1.overflow, bus1.underflow, bus1.count,
                  bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
                  bus0.overflow, bus0.underflow, bus0.count,
                  bus1.dout, bus0.dout};

    // Reference model: contents as a queue, pending pulses, last popped word.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf;
    logic [DW-1:0] m_dreg;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [37:0] expv();
        int n;
        logic [10:0] s;
        logic [DW-1:0] head;
        n    = q.size();
        s    = {n == DEPTH, n == 0, n >= 14, n <= 2, m_ovf, m_unf, 5'(n)};
        head = (n > 0) ? q[0] : 8'h00;
        return {s, s, head, m_dreg};
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dreg = '0;
    endtask

    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        int n;
        wren = w; din = d; rden = r; sclr = c;
        @(posedge clk);
        n = q.size();
        if (c) begin
            model_clear();
        end else begin
            m_ovf = w && (n == DEPTH) && !r;
            m_unf = r && (n == 0);
            if (r && n > 0) m_dreg = q.pop_front();
            if (w && (n < DEPTH || r)) q.push_back(d);
        end
        #1;
        wren = 1'b0; rden = 1'b0; sclr = 1'b0; din = '0;
    endtask

    task automatic test_reset();
        logic [37:0] e;
        reset = 1'b1;
        model_clear();
        #100;
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_state got %h want %h", obs, e); end
        reset = 1'b0;
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL first_write got %h want %h", obs, e); end
        n_vec++;
        if (bus1.dout !== 8'h01) begin
            n_bad++; $display("FAIL first_write_fwft_dout got %h want 01", bus1.dout);
        end
    endtask

    task automatic test_fill();
        logic [37:0] e;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            e = expv();
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL fill[%0d] got %h want %h", i, obs, e); end
        end
        n_vec++;
        if (bus1.count !== 5'd16 || bus1.full !== 1'b1 || bus0.count !== 5'd16) begin
            n_bad++; $display("FAIL fill_full got count %0d full %b want 16 1", bus1.count, bus1.full);
        end
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL overflow_pulse got %h want %h", obs, e); end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL overflow_clear got %h want %h", obs, e); end
    endtask

    task automatic test_drain();
        logic [37:0] e;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            e = expv();
            n_vec++;
            if (obs !== e || bus0.dout !== 8'(i)) begin
                n_bad++; $display("FAIL drain[%0d] got %h want %h", i, obs, e);
            end
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL underflow_pulse got %h want %h", obs, e); end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL underflow_clear got %h want %h", obs, e); end
    endtask

    task automatic test_wrap();
        logic [37:0] e;
        logic [DW-1:0] pat;
        pat = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, pat, 1'b0, 1'b0);
            pat++;
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, pat, 1'b1, 1'b0);
            pat++;
            e = expv();
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL wrap[%0d] got %h want %h", i, obs, e); end
        end
        while (q.size() < DEPTH) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
            e = expv();
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL full_rw[%0d] got %h want %h", i, obs, e); end
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            e = expv();
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL full_drain[%0d] got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_empty_corner();
        logic [37:0] e;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL empty_rw got %h want %h", obs, e); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        e = expv();
        n_vec++;
        if (obs !== e || bus0.dout !== 8'h5A) begin
            n_bad++; $display("FAIL empty_rw_read got %h want %h", obs, e);
        end
    endtask

    task automatic test_random();
        logic [37:0] e;
        bit w, r, c;
        for (int i = 0; i < 400; i++) begin
            w = (i % 100 < 50) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            r = (i % 100 < 50) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            c = ($urandom_range(63) == 0);
            cycle(w, 8'($urandom), r, c);
            e = expv();
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL random[%0d] got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_clear();
        logic [37:0] e;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b1);
        e = expv();
        n_vec++;
        if (obs !== e || bus1.count !== 5'd0) begin
            n_bad++; $display("FAIL sclr_mid got %h want %h", obs, e);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL async_reset got %h want %h", obs, e); end
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        e = expv();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL after_reset got %h want %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_empty_corner();
        test_random();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "bench timeout");
    end
endmodule
